// File: rtl/ili9341_pattern_gen_if.sv
// Pixel-stream handshake between the test-pattern source (master) and the ILI9341 driver (slave).
interface ili9341_pattern_gen_if;
  logic [2:0]  in_mode;
  logic [15:0] in_color;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_pixel;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;
  logic [7:0]  out_frame_count;

  modport master (
    input  in_mode, in_color, in_ready,
    output out_valid, out_pixel, out_sof, out_eol, out_eof, out_frame_count
  );

  modport slave (
    output in_mode, in_color, in_ready,
    input  out_valid, out_pixel, out_sof, out_eol, out_eof, out_frame_count
  );
endinterface

// File: rtl/ili9341_pattern_gen.sv
// RGB565 test-pattern source for the ILI9341 driver: raster-order pixels with a registered,
// full-throughput valid/ready output stage.
//
// state    | meaning
// S_IDLE   | one cycle after reset; registers the (0,0) pixel
// S_STREAM | pixel always offered; the next one is registered on every transfer
module ili9341_pattern_gen #(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 320,
  parameter int BAR_COUNT    = 8,
  parameter int CHECKER_LOG2 = 4,
  parameter int SCROLL_STEP  = 4,
  parameter int BAR_HEIGHT   = 16
) (
  input logic                   in_clk,
  input logic                   in_rst,
  ili9341_pattern_gen_if.master bus
);
  localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BAR_W = WIDTH / BAR_COUNT;
  localparam int SW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [SW-1:0] SEG_LAST = SW'(BAR_W - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [2:0]    bar_q, bar_d;
  logic [2:0]    mode_q, mode_d;
  logic [7:0]    fc_q, fc_d;
  logic [YW-1:0] off_q, off_d;
  logic          valid_q, valid_d;
  logic [15:0]   pixel_q, pixel_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;

  logic          load;
  logic [31:0]   off_sum;
  logic [31:0]   rel;
  logic [31:0]   chk;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    seg_d   = seg_q;
    bar_d   = bar_q;
    mode_d  = mode_q;
    fc_d    = fc_q;
    off_d   = off_q;
    valid_d = valid_q;
    pixel_d = pixel_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    load    = 1'b0;
    off_sum = '0;
    rel     = '0;
    chk     = '0;

    case (state_q)
      S_IDLE: begin
        load    = 1'b1;
        state_d = S_STREAM;
      end
      default: begin
        valid_d = 1'b1;
        if (valid_q && bus.in_ready) begin
          load = 1'b1;
          if (x_q == X_LAST) begin
            x_d   = '0;
            seg_d = '0;
            bar_d = '0;
            if (y_q == Y_LAST) begin
              // frame boundary: new mode and frame count apply to the (0,0) pixel
              y_d     = '0;
              fc_d    = fc_q + 8'd1;
              mode_d  = bus.in_mode;
              off_sum = 32'(off_q) + 32'(SCROLL_STEP);
              if (off_sum >= 32'(HEIGHT)) off_sum = off_sum - 32'(HEIGHT);
              off_d   = YW'(off_sum);
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
            if (seg_q == SEG_LAST) begin
              seg_d = '0;
              bar_d = bar_q + 3'd1;
            end else begin
              seg_d = seg_q + SW'(1);
            end
          end
        end
      end
    endcase

    if (load) begin
      // distance of this line below the scroll offset, modulo the frame height
      rel = (y_d >= off_d) ? (32'(y_d) - 32'(off_d))
                           : (32'(y_d) + 32'(HEIGHT) - 32'(off_d));
      chk = ((32'(x_d) >> CHECKER_LOG2) ^ (32'(y_d) >> CHECKER_LOG2)) & 32'd1;
      case (mode_d)
        3'd1:    pixel_d = bar_color(bar_d);
        3'd2:    pixel_d = (chk != 32'd0) ? 16'h0000 : bus.in_color;
        3'd3:    pixel_d = {5'(32'(x_d) >> 3), 6'(32'(y_d) >> 3), fc_d[4:0]};
        3'd4:    pixel_d = (rel < 32'(BAR_HEIGHT)) ? bus.in_color : 16'h0000;
        default: pixel_d = bus.in_color;
      endcase
      sof_d = (x_d == '0) && (y_d == '0);
      eol_d = (x_d == X_LAST);
      eof_d = (x_d == X_LAST) && (y_d == Y_LAST);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      seg_q   <= '0;
      bar_q   <= '0;
      mode_q  <= bus.in_mode;
      fc_q    <= '0;
      off_q   <= '0;
      valid_q <= 1'b0;
      pixel_q <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      seg_q   <= seg_d;
      bar_q   <= bar_d;
      mode_q  <= mode_d;
      fc_q    <= fc_d;
      off_q   <= off_d;
      valid_q <= valid_d;
      pixel_q <= pixel_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.out_pixel       = pixel_q;
  assign bus.out_sof         = sof_q;
  assign bus.out_eol         = eol_q;
  assign bus.out_eof         = eof_q;
  assign bus.out_frame_count = fc_q;
endmodule

// File: tb/tb_ili9341_pattern_gen.sv
// Bench for ili9341_pattern_gen on a reduced 32x20 frame: per-cycle reference-model compare,
// random stalls and colours, plus literal pixel pins.
`timescale 1ns/1ps
module tb_ili9341_pattern_gen;
  localparam int W    = 32;
  localparam int H    = 20;
  localparam int BC   = 8;
  localparam int CL   = 4;
  localparam int STEP = 4;
  localparam int BH   = 16;
  localparam int NPIX = W * H;
  localparam logic [15:0] BAR_TBL [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic in_clk = 1'b0;
  logic in_rst;

  ili9341_pattern_gen_if bus();

  ili9341_pattern_gen #(
    .WIDTH(W), .HEIGHT(H), .BAR_COUNT(BC), .CHECKER_LOG2(CL),
    .SCROLL_STEP(STEP), .BAR_HEIGHT(BH)
  ) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .bus(bus)
  );

  always #5 in_clk = ~in_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pixel from the pattern rules, using plain division and modulo.
  function automatic logic [15:0] exp_pixel(input int x, input int y, input int mode,
                                            input int fc, input logic [15:0] col);
    int off;
    int rel;
    off = 0;
    rel = 0;
    case (mode)
      1: return BAR_TBL[x / (W / BC)];
      2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 16'h0000 : col;
      3: return 16'((((x >> 3) & 31) << 11) | (((y >> 3) & 63) << 5) | (fc & 31));
      4: begin
        off = (fc * STEP) % H;
        rel = (((y - off) % H) + H) % H;
        return (rel < BH) ? col : 16'h0000;
      end
      default: return col;
    endcase
  endfunction

  // Model of the pixel currently on the output (valid after the most recent rising edge).
  bit          m_known = 1'b0;
  bit          m_idle;
  bit          m_valid;
  int          m_x, m_y, m_fc, m_mode, m_idx;
  logic [15:0] m_pix;
  bit          m_sof, m_eol, m_eof;
  int          xfer_cnt  = 0;
  bit          cnt_armed = 1'b0;

  function automatic void load_pix();
    m_pix = exp_pixel(m_x, m_y, m_mode, m_fc, bus.in_color);
    m_sof = (m_x == 0) && (m_y == 0);
    m_eol = (m_x == W - 1);
    m_eof = (m_x == W - 1) && (m_y == H - 1);
  endfunction

  // Inputs only change shortly after a rising edge, so the falling edge sees what the next rising edge will sample.
  always @(negedge in_clk) begin
    if (m_known) begin
      check("valid", 32'(bus.out_valid), 32'(m_valid));
      check("frame_count", 32'(bus.out_frame_count), 32'(m_fc));
      check("pixel_sof_eol_eof", 32'({bus.out_pixel, bus.out_sof, bus.out_eol, bus.out_eof}),
            32'({m_pix, m_sof, m_eol, m_eof}));
      if (bus.out_valid === 1'b1 && bus.in_ready === 1'b1 && in_rst === 1'b0) begin
        if (bus.out_sof === 1'b1) begin
          xfer_cnt  = 0;
          cnt_armed = 1'b1;
        end
        xfer_cnt++;
        if (bus.out_eof === 1'b1 && cnt_armed) begin
          check("transfers_per_frame", 32'(xfer_cnt), 32'(NPIX));
          cnt_armed = 1'b0;
        end
      end
    end

    if (in_rst === 1'b1) begin
      m_known   = 1'b1;
      m_idle    = 1'b1;
      m_valid   = 1'b0;
      m_pix     = 16'h0000;
      m_sof     = 1'b0;
      m_eol     = 1'b0;
      m_eof     = 1'b0;
      m_fc      = 0;
      m_x       = 0;
      m_y       = 0;
      m_mode    = int'(bus.in_mode);
      cnt_armed = 1'b0;
    end else if (m_known) begin
      if (m_idle) begin
        m_idle = 1'b0;
        load_pix();
      end else begin
        if (m_valid && bus.in_ready === 1'b1) begin
          m_idx = m_y * W + m_x + 1;
          if (m_idx == NPIX) begin
            m_idx  = 0;
            m_fc   = (m_fc + 1) % 256;
            m_mode = int'(bus.in_mode);
          end
          m_x = m_idx % W;
          m_y = m_idx / W;
          load_pix();
        end
        m_valid = 1'b1;
      end
    end
  end

  bit          stall_en   = 1'b0;
  bit          color_rand = 1'b0;
  logic [15:0] color_val  = 16'hF800;

  initial begin : drv
    forever begin
      @(posedge in_clk);
      #2;
      bus.in_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_color = color_rand ? 16'($urandom) : color_val;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge in_clk);
      #1;
    end
  endtask

  task automatic wait_at(input string name, input int x, input int y, input int fc, output bit found);
    found = 1'b0;
    for (int i = 0; i < 4 * NPIX; i++) begin
      if (m_known && m_valid && !m_idle && m_x == x && m_y == y && m_fc == fc) begin
        found = 1'b1;
        return;
      end
      tick(1);
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: pixel (%0d,%0d) of frame %0d not reached within budget", name, x, y, fc);
  endtask

  task automatic expect_px(input string name, input int x, input int y, input int fc,
                           input logic [15:0] px);
    bit found;
    wait_at(name, x, y, fc, found);
    if (found) check(name, 32'(bus.out_pixel), 32'(px));
  endtask

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : main
    bit found;
    in_rst      = 1'b1;
    bus.in_mode = 3'd0;
    tick(3);
    in_rst = 1'b0;
    tick(1);
    check("valid_low_1_edge_after_release", 32'(bus.out_valid), 32'd0);
    tick(1);
    check("valid_high_2_edges_after_release", 32'(bus.out_valid), 32'd1);

    expect_px("solid_first_pixel", 0, 0, 0, 16'hF800);
    check("sof_first_pixel", 32'(bus.out_sof), 32'd1);
    bus.in_mode = 3'd1;
    expect_px("solid_last_pixel", W - 1, H - 1, 0, 16'hF800);
    check("eof_last_pixel", 32'(bus.out_eof), 32'd1);
    tick(1);
    check("frame_count_after_frame0", 32'(bus.out_frame_count), 32'd1);

    expect_px("bars_x0", 0, 0, 1, 16'hFFFF);
    expect_px("bars_x3", 3, 0, 1, 16'hFFFF);
    expect_px("bars_x4", 4, 0, 1, 16'hFFE0);
    expect_px("bars_x8", 8, 0, 1, 16'h07FF);
    expect_px("bars_x20", 20, 0, 1, 16'hF800);
    expect_px("bars_x31", W - 1, 0, 1, 16'h0000);
    check("bars_eol_x31", 32'(bus.out_eol), 32'd1);
    bus.in_mode = 3'd2;
    color_val   = 16'h001F;

    expect_px("checker_0_0", 0, 0, 2, 16'h001F);
    expect_px("checker_16_0", 16, 0, 2, 16'h0000);
    expect_px("checker_15_15", 15, 15, 2, 16'h001F);
    expect_px("checker_0_16", 0, 16, 2, 16'h0000);
    expect_px("checker_16_16", 16, 16, 2, 16'h001F);
    bus.in_mode = 3'd3;
    stall_en    = 1'b1;
    color_rand  = 1'b1;

    expect_px("gradient_9_10", 9, 10, 3, 16'h0823);
    bus.in_mode = 3'd0;
    wait_at("frame4_mid", 0, 5, 4, found);
    bus.in_mode = 3'd4;
    wait_at("frame4_late", 0, 10, 4, found);
    color_rand = 1'b0;
    color_val  = 16'h07E0;

    expect_px("scroll_fc5_line0", 0, 0, 5, 16'h07E0);
    expect_px("scroll_fc5_line15", 0, 15, 5, 16'h07E0);
    expect_px("scroll_fc5_line16", 0, 16, 5, 16'h0000);

    wait_at("reset_point", 20, 17, 5, found);
    in_rst      = 1'b1;
    bus.in_mode = 3'd0;
    tick(1);
    check("reset_valid_low", 32'(bus.out_valid), 32'd0);
    check("reset_frame_count", 32'(bus.out_frame_count), 32'd0);
    check("reset_no_eof", 32'(bus.out_eof), 32'd0);
    tick(1);
    check("reset_held_valid_low_2", 32'(bus.out_valid), 32'd0);
    tick(1);
    check("reset_held_valid_low_3", 32'(bus.out_valid), 32'd0);
    in_rst = 1'b0;

    expect_px("restart_first_pixel", 0, 0, 0, 16'h07E0);
    check("restart_sof", 32'(bus.out_sof), 32'd1);
    wait_at("restart_mid", 10, 8, 0, found);
    bus.in_mode = 3'd4;
    expect_px("scroll_fc1_line0", 0, 0, 1, 16'h0000);
    expect_px("scroll_fc1_line3", 0, 3, 1, 16'h0000);
    expect_px("scroll_fc1_line4", 0, 4, 1, 16'h07E0);
    expect_px("scroll_fc1_line19", W - 1, H - 1, 1, 16'h07E0);
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
